// File: rtl/csa_pkg.sv
// Shared CSA datapath types and the block_perm bit map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_pkg;

   localparam int BYTE_W   = 8;
   // Wide enough for the largest legal requester count (8).
   localparam int ID_MAX_W = 3;

   // PERM_DST[i] is the output bit position that input bit i moves to.
   localparam int PERM_DST [BYTE_W] = '{1, 7, 5, 4, 2, 6, 0, 3};

   typedef struct packed {
      logic [BYTE_W-1:0]   data;
      logic [ID_MAX_W-1:0] id;
   } perm_rsp_t;

endpackage

// File: rtl/block_perm_arb_if.sv
// Request/response bundle between NREQ requesters, the arbiter and its consumer.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester, rsp_ready from the consumer.
interface block_perm_arb_if
   import csa_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]        req_valid;
   logic [BYTE_W*NREQ-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   rsp_valid;
   logic [BYTE_W-1:0]      rsp_data;
   logic [IDW-1:0]         rsp_id;
   logic                   rsp_ready;

   // Requester/consumer side.
   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/block_perm.sv
// Fixed CSA byte permutation: each input bit is wired to one output bit.
// Latency: combinational, zero cycles.
// Backpressure: none.
module block_perm
   import csa_pkg::*;
(
   input  logic [BYTE_W-1:0] in_i,
   output logic [BYTE_W-1:0] out_o
);

   for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
      assign out_o[PERM_DST[i]] = in_i[i];
   end

endmodule

// File: rtl/block_perm_arb.sv
// Round-robin share of one block_perm among NREQ requesters, result in a 1-entry register.
// Latency: byte accepted on edge N is on rsp_data after edge N.
// Backpressure: req_ready is zero while the held response is not being taken.
module block_perm_arb
   import csa_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   block_perm_arb_if.slave  bus
);

   logic [IDW-1:0]    ptr_q, ptr_d;
   logic              rsp_vld_q, rsp_vld_d;
   perm_rsp_t         rsp_q, rsp_d;

   logic [IDW-1:0]    win;
   logic              any_vld;
   logic              slot_free;
   logic              xfer;
   logic [BYTE_W-1:0] sel_byte;
   logic [BYTE_W-1:0] perm_byte;
   logic              unused_id;

   // Rotate so the pointer's requester sits at bit 0, pick the lowest set bit,
   // then rotate the index back into requester numbering.
   function automatic logic [IDW-1:0] rr_pick(
      input  logic [NREQ-1:0] vld,
      input  logic [IDW-1:0]  p,
      output logic            found
   );
      logic [NREQ-1:0] rot;
      logic [IDW-1:0]  idx;
      int              src;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         src = k + int'(p);
         if (src >= NREQ) src = src - NREQ;
         rot[k] = vld[src];
      end
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx   = IDW'(k);
            found = 1'b1;
         end
      end
      src = int'(idx) + int'(p);
      if (src >= NREQ) src = src - NREQ;
      return IDW'(src);
   endfunction

   // Grant: winner from the pointer, accepted only when the output slot can take it.
   always_comb begin
      any_vld       = 1'b0;
      win           = rr_pick(bus.req_valid, ptr_q, any_vld);
      slot_free     = !rsp_vld_q || bus.rsp_ready;
      xfer          = any_vld && slot_free && !rst;
      bus.req_ready = '0;
      if (xfer) bus.req_ready[win] = 1'b1;
      sel_byte      = bus.req_data[BYTE_W*int'(win) +: BYTE_W];
   end

   block_perm u_perm (
      .in_i  (sel_byte),
      .out_o (perm_byte)
   );

   // Next state: load on transfer (replacing any drained result), clear on drain only.
   always_comb begin
      rsp_vld_d = rsp_vld_q;
      rsp_d     = rsp_q;
      ptr_d     = ptr_q;
      if (xfer) begin
         rsp_vld_d  = 1'b1;
         rsp_d.data = perm_byte;
         rsp_d.id   = ID_MAX_W'(win);
         ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end else if (rsp_vld_q && bus.rsp_ready) begin
         rsp_vld_d  = 1'b0;
      end
   end

   // State registers; reset drops any pending response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld_q <= 1'b0;
         rsp_q     <= '0;
         ptr_q     <= '0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
         rsp_q     <= rsp_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_data  = rsp_q.data;
   assign bus.rsp_id    = rsp_q.id[IDW-1:0];
   // The id field is sized for 8 requesters; upper bits are zero for smaller NREQ.
   assign unused_id     = ^rsp_q.id;

endmodule

// File: tb/tb_block_perm_arb.sv
// Bench for block_perm_arb: reference model plus directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_block_perm_arb;
   import csa_pkg::*;

   localparam int N = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   block_perm_arb_if #(.NREQ(N)) bus ();

   block_perm_arb #(.NREQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_grant(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] m_perm(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) r[PERM_DST[i]] = b[i];
      return r;
   endfunction

   int         m_ptr;
   bit         m_vld;
   logic [7:0] m_data;
   int         m_id;

   always @(posedge clk or posedge rst) begin
      int g;
      if (rst) begin
         m_ptr  <= 0;
         m_vld  <= 1'b0;
         m_data <= 8'h00;
         m_id   <= 0;
      end else begin
         g = m_grant(bus.req_valid, m_ptr);
         if (g >= 0 && (!m_vld || bus.rsp_ready)) begin
            m_vld  <= 1'b1;
            m_data <= m_perm(bus.req_data[8*g +: 8]);
            m_id   <= g;
            m_ptr  <= (g + 1) % N;
         end else if (m_vld && bus.rsp_ready) begin
            m_vld  <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int         g;
      logic [N-1:0] er;
      if (!rst) begin
         g  = m_grant(bus.req_valid, m_ptr);
         er = '0;
         if (g >= 0 && (!m_vld || bus.rsp_ready)) er[g] = 1'b1;
         chk("mdl_req_ready", 32'(bus.req_ready), 32'(er));
         chk("mdl_rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
         if (m_vld) begin
            chk("mdl_rsp_data", 32'(bus.rsp_data), 32'(m_data));
            chk("mdl_rsp_id", 32'(bus.rsp_id), 32'(m_id));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [7:0]   t2_data [4];
   logic [1:0]   t2_id   [4];
   logic [N-1:0] rr;

   initial begin
      t2_data = '{8'h80, 8'h01, 8'h08, 8'hFD};
      t2_id   = '{2'd0, 2'd1, 2'd2, 2'd3};
      rst           = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_data  = 32'h0;
      bus.rsp_ready = 1'b0;
      #2;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      bus.req_valid = 4'b0000;
      tick();
      tick();
      rst = 1'b0;

      // single request
      bus.req_valid = 4'b0001;
      bus.req_data  = 32'h0000_0001;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t1_rsp_data",  32'(bus.rsp_data),  32'h02);
      chk("t1_rsp_id",    32'(bus.rsp_id),    32'h0);
      tick();

      // all four requesting, back-to-back
      do_reset();
      bus.req_valid = 4'b1111;
      bus.req_data  = 32'hFE80_4002;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_grant", 32'(bus.req_ready), 32'(1 << k));
         if (k > 0) begin
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("t2_rsp_data",  32'(bus.rsp_data),  32'(t2_data[k-1]));
            chk("t2_rsp_id",    32'(bus.rsp_id),    32'(t2_id[k-1]));
         end
         rr = bus.req_ready;
         tick();
         bus.req_valid = bus.req_valid & ~rr;
      end
      @(negedge clk);
      chk("t2_last_data", 32'(bus.rsp_data), 32'hFD);
      chk("t2_last_id",   32'(bus.rsp_id),   32'h3);
      tick();
      @(negedge clk);
      chk("t2_drain", 32'(bus.rsp_valid), 32'h0);
      tick();

      // backpressure
      bus.req_valid = 4'b0001;
      bus.req_data  = 32'h0000_0007;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("t3_accept", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'b0100;
      bus.req_data  = 32'h0001_0007;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_stall_ready", 32'(bus.req_ready), 32'h0);
         chk("t3_stall_valid", 32'(bus.rsp_valid), 32'h1);
         chk("t3_stall_data",  32'(bus.rsp_data),  32'hA2);
         chk("t3_stall_id",    32'(bus.rsp_id),    32'h0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_resume", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("t3_new_data", 32'(bus.rsp_data), 32'h02);
      chk("t3_new_id",   32'(bus.rsp_id),   32'h2);
      tick();

      // pointer fairness with an idle cycle first
      tick();
      bus.req_valid = 4'b1010;
      bus.req_data  = 32'h0100_8000;
      @(negedge clk);
      chk("t4_first", 32'(bus.req_ready), 32'h8);
      rr = bus.req_ready;
      tick();
      bus.req_valid = bus.req_valid & ~rr;
      @(negedge clk);
      chk("t4_second", 32'(bus.req_ready), 32'h2);
      chk("t4_rsp3_data", 32'(bus.rsp_data), 32'h02);
      chk("t4_rsp3_id",   32'(bus.rsp_id),   32'h3);
      rr = bus.req_ready;
      tick();
      bus.req_valid = bus.req_valid & ~rr;
      bus.rsp_ready = 1'b0;

      // reset mid-stream with a response held and requests pending
      bus.req_valid = 4'b1101;
      bus.req_data  = 32'h1122_3344;
      @(negedge clk);
      chk("t4_rsp1_data", 32'(bus.rsp_data), 32'h08);
      chk("t4_rsp1_id",   32'(bus.rsp_id),   32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("t5_rsp_data",  32'(bus.rsp_data),  32'h0);
      chk("t5_rsp_id",    32'(bus.rsp_id),    32'h0);
      chk("t5_req_ready", 32'(bus.req_ready), 32'h0);
      tick();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t5_first_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("t5_rsp_data0", 32'(bus.rsp_data), 32'h21);
      chk("t5_rsp_id0",   32'(bus.rsp_id),   32'h0);
      tick();

      // every byte through requester 1
      for (int v = 0; v < 256; v++) begin
         bus.req_valid = 4'b0010;
         bus.req_data  = 32'(v) << 8;
         @(negedge clk);
         tick();
         if (v == 8'hFF) chk("t6_ff", 32'(bus.rsp_data), 32'hFF);
         if (v == 8'h55) chk("t6_55", 32'(bus.rsp_data), 32'h27);
      end
      bus.req_valid = 4'b0000;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule
